// File: rtl/gb_spi_flashmem_if.sv
// Request/response bus and SPI pins of the flash reader, grouped as one bundle.
// master = requester plus flash side, slave = the reader block.
interface gb_spi_flashmem_if;
  logic        valid;
  logic [23:0] addr;
  logic        ready;
  logic [31:0] rdata;
  logic        spi_csn;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso;

  modport master (
    output valid, addr, spi_miso,
    input  ready, rdata, spi_csn, spi_sck, spi_mosi
  );

  modport slave (
    input  valid, addr, spi_miso,
    output ready, rdata, spi_csn, spi_sck, spi_mosi
  );
endinterface

// File: rtl/gb_spi_flashmem.sv
// Word-read engine for a SPI NOR flash (mode 0, READ 0x03) with release-from-power-down
// at start-up and sequential streaming that keeps CSN low between consecutive words.
module gb_spi_flashmem #(
  parameter int HALF_PERIOD = 1,
  parameter int WAKE_CYCLES = 64
) (
  input  logic              clk,
  input  logic              resetn,
  gb_spi_flashmem_if.slave  bus
);

  localparam int DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int CNT_W = $clog2(WAKE_CYCLES + 2);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);
  localparam logic [7:0]       CMD_WAKE  = 8'hAB;
  localparam logic [7:0]       CMD_READ  = 8'h03;
  localparam logic [5:0]       WORD_BITS = 6'd32;

  typedef enum logic [3:0] {
    S_WAKE, S_WAKE_WAIT, S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE, S_STREAM, S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic             csn_q, csn_d;
  logic             sck_q, sck_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]      tx_q, tx_d;
  logic [31:0]      rx_q, rx_d;
  logic [23:0]      addr_q, addr_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             ready_q, ready_d;

  logic       shifting, div_wrap, sck_rise, sck_fall, last_bit, start_read;
  logic [5:0] phase_last;

  // The SCK divider only runs while bits are moving; the DATA tail cycle (bit_q == 32)
  // leaves SCK low for one cycle so the word can be byte-swapped into rdata.
  always_comb begin
    phase_last = 6'd31;
    case (state_q)
      S_WAKE, S_CMD: phase_last = 6'd7;
      S_ADDR:        phase_last = 6'd23;
      default:       phase_last = 6'd31;
    endcase
  end

  assign shifting = (state_q == S_WAKE && !csn_q) || (state_q == S_CMD) ||
                    (state_q == S_ADDR) || (state_q == S_DATA && bit_q != WORD_BITS);
  assign div_wrap = (div_q == DIV_LAST);
  assign sck_rise = shifting && div_wrap && !sck_q;
  assign sck_fall = shifting && div_wrap && sck_q;
  assign last_bit = (bit_q == phase_last);

  // NOTE: every _d gets its hold value before any branch, so no path leaves a
  // combinational output unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    csn_d      = csn_q;
    sck_d      = sck_q;
    div_d      = div_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    start_read = 1'b0;

    if (shifting) begin
      if (div_wrap) begin
        div_d = '0;
        sck_d = ~sck_q;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
    if (sck_rise && state_q == S_DATA) rx_d = {rx_q[30:0], bus.spi_miso};
    // MOSI moves on the falling edge; zeros shift in so MOSI idles low afterwards.
    if (sck_fall) begin
      bit_d = bit_q + 6'd1;
      tx_d  = {tx_q[22:0], 1'b0};
    end

    case (state_q)
      S_WAKE: begin
        if (csn_q) begin
          csn_d = 1'b0;
          tx_d  = {CMD_WAKE, 16'h0000};
          div_d = '0;
          bit_d = '0;
          sck_d = 1'b0;
        end else if (sck_fall && last_bit) begin
          csn_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_WAKE_WAIT;
        end
      end
      S_WAKE_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = S_IDLE;
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end
      S_IDLE: begin
        if (bus.valid) begin
          addr_d     = bus.addr;
          start_read = 1'b1;
        end
      end
      S_CMD: begin
        if (sck_fall && last_bit) begin
          state_d = S_ADDR;
          bit_d   = '0;
          tx_d    = addr_q;
        end
      end
      S_ADDR: begin
        if (sck_fall && last_bit) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_q == WORD_BITS) begin
          state_d = S_DONE;
          ready_d = 1'b1;
          rdata_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
        end
      end
      S_DONE: state_d = S_STREAM;
      S_STREAM: begin
        // Flash keeps auto-incrementing while CSN stays low, so the next word is just more clocks.
        if (bus.valid) begin
          addr_d = bus.addr;
          if (bus.addr == addr_q + 24'd4) begin
            state_d = S_DATA;
            bit_d   = '0;
            div_d   = '0;
          end else begin
            state_d = S_GAP;
            csn_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(1)) start_read = 1'b1;
        else                    cnt_d      = cnt_q + CNT_W'(1);
      end
      default: state_d = S_WAKE;
    endcase

    if (start_read) begin
      state_d = S_CMD;
      csn_d   = 1'b0;
      tx_d    = {CMD_READ, 16'h0000};
      div_d   = '0;
      bit_d   = '0;
      sck_d   = 1'b0;
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_WAKE;
      csn_q   <= 1'b1;
      sck_q   <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      csn_q   <= csn_d;
      sck_q   <= sck_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.rdata    = rdata_q;
  assign bus.spi_csn  = csn_q;
  assign bus.spi_sck  = sck_q;
  assign bus.spi_mosi = tx_q[23];

endmodule
